// File: rtl/ofs_plat_prim_burstcount1_burst_buffer.sv
// ofs_plat_prim_burstcount1_burst_buffer: store-and-forward FIFO that releases a burst only once its last flit is stored.
module ofs_plat_prim_burstcount1_burst_buffer #(
    parameter int DATA_WIDTH = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [BURST_CNT_WIDTH-1:0] in_burstcount,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [BURST_CNT_WIDTH-1:0] out_burstcount,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic                       err_burst
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = BURST_CNT_WIDTH;
    localparam logic [BW-1:0] MAX_BC = BW'(2 ** (BW - 1));
    localparam logic [BW-1:0] ONE = BW'(1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2 ** (BW - 1))) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2**(BURST_CNT_WIDTH-1)");
    end

    typedef struct packed {
        logic [BW-1:0]         bc;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d, cb_q, cb_d;
    logic          init_q;
    logic          in_sop_q, in_sop_d, out_sop_q, out_sop_d, err_q, err_d;
    logic [BW-1:0] in_rem_q, in_rem_d, in_bc_q, in_bc_d, out_rem_q, out_rem_d;
    logic          push, pop, in_legal, in_eop, out_eop_raw;
    logic [BW-1:0] in_eff_bc;

    always_comb begin
        in_ready = init_q && (occ_q < FULL);
        push = in_valid && in_ready;
        in_legal = (in_burstcount != '0) && (in_burstcount <= MAX_BC);
        // Illegal lengths collapse to a single-beat burst so the stream stays framed.
        in_eff_bc = in_sop_q ? (in_legal ? in_burstcount : ONE) : in_bc_q;
        in_eop = in_sop_q ? (in_eff_bc == ONE) : (in_rem_q == ONE);
        out_valid = (occ_q != '0) && (cb_q != '0);
        out_data = mem_q[rd_ptr_q].data;
        out_burstcount = mem_q[rd_ptr_q].bc;
        out_eop_raw = out_sop_q ? (out_burstcount == ONE) : (out_rem_q == ONE);
        out_eop = out_valid && out_eop_raw;
        out_sop = out_sop_q;
        err_burst = err_q;
        pop = out_valid && out_ready;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        occ_d = occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
        cb_d = cb_q + (AW + 1)'(push && in_eop) - (AW + 1)'(pop && out_eop);
        in_sop_d = push ? in_eop : in_sop_q;
        in_rem_d = push ? (in_sop_q ? in_eff_bc - ONE : in_rem_q - ONE) : in_rem_q;
        in_bc_d = push ? in_eff_bc : in_bc_q;
        out_sop_d = pop ? out_eop_raw : out_sop_q;
        out_rem_d = pop ? (out_sop_q ? out_burstcount - ONE : out_rem_q - ONE) : out_rem_q;
        err_d = err_q || (push && in_sop_q && !in_legal);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            cb_q      <= '0;
            in_sop_q  <= 1'b1;
            in_rem_q  <= '0;
            in_bc_q   <= '0;
            out_sop_q <= 1'b1;
            out_rem_q <= '0;
            err_q     <= 1'b0;
        end else begin
            init_q    <= 1'b1;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            cb_q      <= cb_d;
            in_sop_q  <= in_sop_d;
            in_rem_q  <= in_rem_d;
            in_bc_q   <= in_bc_d;
            out_sop_q <= out_sop_d;
            out_rem_q <= out_rem_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{bc: in_eff_bc, data: in_data};
    end
endmodule

// File: tb/tb_ofs_plat_prim_burstcount1_burst_buffer.sv
// tb_ofs_plat_prim_burstcount1_burst_buffer: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_ofs_plat_prim_burstcount1_burst_buffer;
    localparam int DW = 32;
    localparam int BW = 7;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [BW-1:0] bc;
        logic          sop;
        logic          eop;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [BW-1:0] in_burstcount = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [BW-1:0] out_burstcount;
    logic          out_sop, out_eop, err_burst;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    ofs_plat_prim_burstcount1_burst_buffer #(
        .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_burstcount(in_burstcount),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_burstcount(out_burstcount),
        .out_sop(out_sop), .out_eop(out_eop), .err_burst(err_burst)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted output flit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_flit", 64'(out_data), 64'hffff_ffff_ffff_ffff);
            end else begin
                check("out_flit", 64'({out_data, out_burstcount, out_sop, out_eop}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [BW-1:0] bc);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_burstcount = bc;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_flit(input logic [DW-1:0] d, input logic [BW-1:0] bc, input logic sop, input logic eop);
        exp_q.push_back('{d: d, bc: bc, sop: sop, eop: eop});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sop", 64'(out_sop), 64'd1);
        check("rst_out_eop", 64'(out_eop), 64'd0);
        check("rst_err", 64'(err_burst), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_first_clk", 64'(in_ready), 64'd0);
        tick(1);
        check("in_ready_after_first_clk", 64'(in_ready), 64'd1);

        // Four-beat burst held until its last flit arrives, then streamed.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_flit(DW'(32'hA0 + i), 7'd4, i == 0, i == 3);
            send(DW'(32'hA0 + i), 7'd4);
            check("b4_out_valid_latency", 64'(out_valid), 64'(i == 3));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b4_stream", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        check("b4_done", 64'(out_valid), 64'd0);
        tick(1);

        // Single-beat bursts back to back.
        for (int i = 0; i < 6; i++) begin
            expect_flit(DW'(32'hB0 + i), 7'd1, 1'b1, 1'b1);
            send(DW'(32'hB0 + i), 7'd1);
            if (i == 0) check("single_latency", 64'(out_valid), 64'd1);
        end
        drain();

        // Fill to DEPTH with two 32-beat bursts, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            expect_flit(DW'(32'h1000 + i), 7'd32, (i % 32) == 0, (i % 32) == 31);
            send(DW'(32'h1000 + i), 7'd32);
        end
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        tick(1);
        out_ready = 1'b1;
        @(negedge clk);
        check("full_in_ready_before_pop", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("in_ready_after_pop", 64'(in_ready), 64'd1);
        drain();

        // Partial burst stays parked until completed; later burstcounts ignored.
        expect_flit(32'h40, 7'd4, 1'b1, 1'b0);
        expect_flit(32'h41, 7'd4, 1'b0, 1'b0);
        expect_flit(32'h42, 7'd4, 1'b0, 1'b0);
        expect_flit(32'h43, 7'd4, 1'b0, 1'b1);
        send(32'h40, 7'd4);
        send(32'h41, 7'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("partial_hold", 64'(out_valid), 64'd0);
        end
        tick(1);
        send(32'h42, 7'd7);
        send(32'h43, 7'd0);
        check("partial_release", 64'(out_valid), 64'd1);
        drain();

        // Illegal burstcounts become single beats and set the sticky error.
        expect_flit(32'hE0, 7'd1, 1'b1, 1'b1);
        send(32'hE0, 7'd0);
        check("err_set", 64'(err_burst), 64'd1);
        expect_flit(32'hE1, 7'd1, 1'b1, 1'b1);
        send(32'hE1, 7'd65);
        expect_flit(32'hE2, 7'd2, 1'b1, 1'b0);
        expect_flit(32'hE3, 7'd2, 1'b0, 1'b1);
        send(32'hE2, 7'd2);
        send(32'hE3, 7'd9);
        drain();
        check("err_sticky", 64'(err_burst), 64'd1);

        // Reset mid-burst discards the partial burst.
        send(32'h60, 7'd8);
        send(32'h61, 7'd8);
        send(32'h62, 7'd8);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_err", 64'(err_burst), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(1);
        @(negedge clk);
        check("postrst_out_valid", 64'(out_valid), 64'd0);
        tick(1);
        expect_flit(32'h70, 7'd2, 1'b1, 1'b0);
        expect_flit(32'h71, 7'd2, 1'b0, 1'b1);
        send(32'h70, 7'd2);
        send(32'h71, 7'd0);
        drain();
        tick(3);
        check("final_out_valid", 64'(out_valid), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ofs_plat_prim_burstcount1_burst_buffer.md
OFS_PLAT_PRIM_BURSTCOUNT1_BURST_BUFFER -- requirements
Module: ofs_plat_prim_burstcount1_burst_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, payload bits per flit.
REQ-002 SHALL have parameter BURST_CNT_WIDTH, default 7, burstcount width with origin 1 (1 = one beat, 0 illegal).
REQ-003 SHALL have parameter DEPTH, default 64, flit storage entries; power of 2 and >= 2**(BURST_CNT_WIDTH-1); elaboration fails otherwise.
REQ-004 clk  in  1  sole clock; all state on posedge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  input flit present.
REQ-007 in_ready  out  1  buffer can accept a flit this cycle.
REQ-008 in_data  in  DATA_WIDTH  input flit payload.
REQ-009 in_burstcount  in  BURST_CNT_WIDTH  burst length; sampled only on SOP flits.
REQ-010 out_valid  out  1  output flit present.
REQ-011 out_ready  in  1  downstream accepts flit.
REQ-012 out_data  out  DATA_WIDTH  output flit payload.
REQ-013 out_burstcount  out  BURST_CNT_WIDTH  burst length of the current burst, held on every flit of that burst.
REQ-014 out_sop, out_eop  out  1 each  first/last flit of burst; both high on single-beat bursts.
REQ-015 err_burst  out  1  sticky: illegal burstcount seen.

Function
REQ-016 Input handshake: flit accepted when in_valid && in_ready; in_ready = (occupancy < DEPTH), from registered occupancy only, never combinationally dependent on out_ready.
REQ-017 Input tracker: flags SOP on the first accepted flit after reset and on the flit after each EOP; at SOP loads rem = in_burstcount-1; otherwise decrements rem; EOP = (SOP && in_burstcount==1) || (!SOP && rem==1).
REQ-018 Each entry stores in_data plus the burstcount latched at SOP of its burst.
REQ-019 complete_bursts counter (width log2(DEPTH)+1): +1 on accepted input EOP flit, -1 on accepted output EOP flit, unchanged when both occur in the same cycle.
REQ-020 out_valid = (occupancy != 0) && (complete_bursts != 0); no flit of a burst leaves before its EOP flit is stored (store-and-forward per burst).
REQ-021 Output handshake: flit leaves when out_valid && out_ready; out_data/out_burstcount/out_sop/out_eop stable while out_valid && !out_ready.
REQ-022 Output tracker: identical SOP/EOP algorithm to REQ-017, driven by stored burstcount and output acceptances.
REQ-023 Latency: first flit of a burst presentable on out the cycle after its input EOP flit is accepted; back-to-back completed bursts stream with no bubble.
REQ-024 Throughput: one flit in and one flit out per cycle sustained; simultaneous push and pop when full is not permitted (in_ready low); when empty, a flit cannot bypass storage.
REQ-025 Occupancy and read/write pointers wrap modulo DEPTH; occupancy never exceeds DEPTH or goes below 0.
REQ-026 Illegal burstcount (0, or > 2**(BURST_CNT_WIDTH-1)) at input SOP: flit treated as single-beat burst (EOP), stored burstcount forced to 1, err_burst set.

Reset
REQ-027 reset_n low asynchronously clears pointers, occupancy, complete_bursts, both trackers to SOP with rem=0, err_burst=0.
REQ-028 During reset: in_ready=0, out_valid=0, out_sop=1, out_eop=0; in_ready rises the first clock after reset_n deasserts.
REQ-029 Reset mid-burst discards all stored flits including partial bursts; next accepted flit is SOP.
REQ-030 Storage contents need no reset.

Verification
REQ-031 Burst 4 flits D0..D3, out_ready=1 -> out_valid low until cycle after D3 accepted; then D0..D3 consecutive, burstcount 4, sop on D0, eop on D3.
REQ-032 Single-beat bursts burstcount=1 every cycle, out_ready=1 -> one flit/cycle out after 1-cycle latency, sop=eop=1 each.
REQ-033 Fill DEPTH=64 with two 32-beat bursts, out_ready=0 -> in_ready=0 at 64 flits; out_ready=1 -> 64 flits drain in order, in_ready high cycle after first pop.
REQ-034 Partial burst (2 of 4 flits) then idle -> out_valid stays 0; remaining 2 flits -> burst emitted intact.
REQ-035 in_burstcount=0 at SOP -> err_burst=1 sticky, flit emitted with sop=eop=1, burstcount 1; following burst unaffected.
REQ-036 reset_n pulsed low after 3 of 8 flits -> out_valid=0, occupancy 0; fresh 2-beat burst passes normally.
